// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU execute stage.
//   - default data/address widths
//   - opcode encoding seen on i_op / ex_op
//   - state encoding of the sequential multiplier
package cpu_pkg;

  localparam int CPU_DW = 16;
  localparam int CPU_AW = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // Opcodes that produce a register write (ADD..MUL).
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

  // Opcodes that update the zero/carry flags.
  function automatic logic op_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/mul16_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset (async, active-low)
//   start      - operands valid, begin a multiply when idle
//   flush      - abort any multiply in progress
//   mcand_in, mplier_in - operands captured on the IDLE->BUSY edge
//   busy, done - FSM in BUSY / DONE
//   product    - low DW bits of mcand*mplier, valid while done
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | DW shift-add iterations, cnt = iteration index
// DONE  | product valid for one cycle, then back to IDLE
module mul16_seq #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          flush,
  input  logic [DW-1:0] mcand_in,
  input  logic [DW-1:0] mplier_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DW);

  mul_state_t    state, state_d;
  logic [DW-1:0] acc;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            acc    <= '0;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (!flush) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start && !flush) state_d = ST_BUSY;
      ST_BUSY: begin
        if (flush)                    state_d = ST_IDLE;
        else if (cnt == CW'(DW - 1))  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit CPU.
// Latches decoded operands (ID/EX), computes the ALU or sequential MUL
// result, forwards it to the register file, and registers it into the
// EX/WB latch that drives the register-file write port.
// Ports:
//   clk, reset (async, active-low)
//   i_valid, i_op, i_dest, i_wb, i_data_a, i_data_b - decoded instruction
//   i_flush        - kill instruction in EX, abort multiply
//   o_stall        - front end holds inputs and PC
//   forwardE, forward_addE, forward_dataE - EX forwarding path
//   o_write_en, o_write_add, o_write_data - write-back port
//   o_zero, o_carry - status flags (ADD/SUB/CMP only)
module execute_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [3:0]    i_op,
  input  logic [AW-1:0] i_dest,
  input  logic          i_wb,
  input  logic [DW-1:0] i_data_a,
  input  logic [DW-1:0] i_data_b,
  input  logic          i_flush,
  output logic          o_stall,
  output logic          forwardE,
  output logic [AW-1:0] forward_addE,
  output logic [DW-1:0] forward_dataE,
  output logic          o_write_en,
  output logic [AW-1:0] o_write_add,
  output logic [DW-1:0] o_write_data,
  output logic          o_zero,
  output logic          o_carry
);
  import cpu_pkg::*;

  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [AW-1:0] ex_dest;
  logic          ex_wb;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;

  logic          mul_start;
  logic          mul_busy;
  logic          mul_done;
  logic [DW-1:0] mul_product;

  logic [DW:0]   sum;
  logic [DW-1:0] result;

  // ID/EX latch; flush wins over a new load, even while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_NOP;
      ex_dest  <= '0;
      ex_wb    <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else if (i_flush) begin
      ex_valid <= 1'b0;
    end else if (!o_stall) begin
      ex_valid <= i_valid;
      ex_op    <= i_op;
      ex_dest  <= i_dest;
      ex_wb    <= i_wb;
      ex_a     <= i_data_a;
      ex_b     <= i_data_b;
    end
  end

  assign mul_start = ex_valid && (ex_op == OP_MUL);

  mul16_seq #(.DW(DW)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .flush     (i_flush),
    .mcand_in  (ex_a),
    .mplier_in (ex_b),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product)
  );

  // Stalled from the latch cycle (still IDLE) through the last BUSY cycle.
  assign o_stall = mul_start && (mul_busy || !mul_done);

  always_comb begin
    sum    = '0;
    result = '0;
    case (ex_op)
      OP_ADD: begin
        sum    = {1'b0, ex_a} + {1'b0, ex_b};
        result = sum[DW-1:0];
      end
      OP_SUB, OP_CMP: begin
        // bit DW of the wide difference is the borrow (A < B)
        sum    = {1'b0, ex_a} - {1'b0, ex_b};
        result = sum[DW-1:0];
      end
      OP_AND: result = ex_a & ex_b;
      OP_OR:  result = ex_a | ex_b;
      OP_XOR: result = ex_a ^ ex_b;
      OP_NOT: result = ~ex_a;
      OP_SHL: result = ex_a << ex_b[3:0];
      OP_SHR: result = ex_a >> ex_b[3:0];
      OP_MOV: result = ex_b;
      OP_MUL: result = mul_product;
      default: result = '0;
    endcase
  end

  assign forwardE      = ex_valid && ex_wb && !o_stall && (ex_op != OP_CMP);
  assign forward_addE  = ex_dest;
  assign forward_dataE = result;

  // EX/WB latch; address, data and flags hold across a stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_write_en   <= 1'b0;
      o_write_add  <= '0;
      o_write_data <= '0;
      o_zero       <= 1'b0;
      o_carry      <= 1'b0;
    end else if (o_stall) begin
      o_write_en <= 1'b0;
    end else begin
      o_write_en   <= ex_valid && ex_wb && op_writes(ex_op);
      o_write_add  <= ex_dest;
      o_write_data <= result;
      if (ex_valid && op_flags(ex_op)) begin
        o_zero  <= (result == '0);
        o_carry <= sum[DW];
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [3:0]  i_op;
  logic [3:0]  i_dest;
  logic        i_wb;
  logic [15:0] i_data_a;
  logic [15:0] i_data_b;
  logic        i_flush;
  logic        o_stall;
  logic        forwardE;
  logic [3:0]  forward_addE;
  logic [15:0] forward_dataE;
  logic        o_write_en;
  logic [3:0]  o_write_add;
  logic [15:0] o_write_data;
  logic        o_zero;
  logic        o_carry;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .i_op          (i_op),
    .i_dest        (i_dest),
    .i_wb          (i_wb),
    .i_data_a      (i_data_a),
    .i_data_b      (i_data_b),
    .i_flush       (i_flush),
    .o_stall       (o_stall),
    .forwardE      (forwardE),
    .forward_addE  (forward_addE),
    .forward_dataE (forward_dataE),
    .o_write_en    (o_write_en),
    .o_write_add   (o_write_add),
    .o_write_data  (o_write_data),
    .o_zero        (o_zero),
    .o_carry       (o_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] dest,
                       input logic wb, input logic [15:0] a, input logic [15:0] b);
    i_valid  = v;
    i_op     = op;
    i_dest   = dest;
    i_wb     = wb;
    i_data_a = a;
    i_data_b = b;
  endtask

  task automatic bubble();
    drive(1'b0, OP_NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, o_stall, 0);
    chk({tag, "_fwd"}, forwardE, 0);
    chk({tag, "_fwd_add"}, forward_addE, 0);
    chk({tag, "_fwd_data"}, forward_dataE, 0);
    chk({tag, "_wen"}, o_write_en, 0);
    chk({tag, "_wadd"}, o_write_add, 0);
    chk({tag, "_wdata"}, o_write_data, 0);
    chk({tag, "_zero"}, o_zero, 0);
    chk({tag, "_carry"}, o_carry, 0);
  endtask

  // Issue a MUL, count stall cycles, then check DONE forwarding and write-back.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] dest, input logic [15:0] exp);
    int n;
    drive(1'b1, OP_MUL, dest, 1'b1, a, b);
    tick();
    bubble();
    n = 0;
    while (o_stall && n < 40) begin
      chk({tag, "_wen_in_stall"}, o_write_en, 0);
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, n, 17);
    chk({tag, "_fwd"}, forwardE, 1);
    chk({tag, "_fwd_add"}, forward_addE, dest);
    chk({tag, "_fwd_data"}, forward_dataE, exp);
    tick();
    chk({tag, "_wen"}, o_write_en, 1);
    chk({tag, "_wadd"}, o_write_add, dest);
    chk({tag, "_wdata"}, o_write_data, exp);
  endtask

  logic [3:0]  tbl_op  [6];
  logic [15:0] tbl_exp [6];

  initial begin
    reset   = 1'b0;
    i_flush = 1'b0;
    bubble();

    tbl_op[0] = OP_AND; tbl_exp[0] = 16'hF000;
    tbl_op[1] = OP_OR;  tbl_exp[1] = 16'hFFF0;
    tbl_op[2] = OP_XOR; tbl_exp[2] = 16'h0FF0;
    tbl_op[3] = OP_NOT; tbl_exp[3] = 16'h0F0F;
    tbl_op[4] = OP_MOV; tbl_exp[4] = 16'hFF00;
    tbl_op[5] = 4'd13;  tbl_exp[5] = 16'h0000;

    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // ADD 0x7FFF + 1
    drive(1'b1, OP_ADD, 4'd3, 1'b1, 16'h7FFF, 16'h0001);
    tick();
    bubble();
    chk("add_fwd", forwardE, 1);
    chk("add_fwd_add", forward_addE, 3);
    chk("add_fwd_data", forward_dataE, 16'h8000);
    chk("add_stall", o_stall, 0);
    tick();
    chk("add_wen", o_write_en, 1);
    chk("add_wadd", o_write_add, 3);
    chk("add_wdata", o_write_data, 16'h8000);
    chk("add_zero", o_zero, 0);
    chk("add_carry", o_carry, 0);
    chk("add_fwd_after", forwardE, 0);

    // SUB 5-5 then CMP 3-4, back to back
    drive(1'b1, OP_SUB, 4'd2, 1'b1, 16'd5, 16'd5);
    tick();
    chk("sub_fwd", forwardE, 1);
    chk("sub_fwd_data", forward_dataE, 16'h0000);
    drive(1'b1, OP_CMP, 4'd5, 1'b1, 16'd3, 16'd4);
    tick();
    bubble();
    chk("sub_wen", o_write_en, 1);
    chk("sub_wadd", o_write_add, 2);
    chk("sub_wdata", o_write_data, 16'h0000);
    chk("sub_zero", o_zero, 1);
    chk("sub_carry", o_carry, 0);
    chk("cmp_fwd", forwardE, 0);
    tick();
    chk("cmp_wen", o_write_en, 0);
    chk("cmp_zero", o_zero, 0);
    chk("cmp_carry", o_carry, 1);

    // logic ops back to back, last one an unused opcode
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl_op[i], 4'(8 + i), 1'b1, 16'hF0F0, 16'hFF00);
      tick();
      if (i < 5) chk($sformatf("logic%0d_fwd_data", i), forward_dataE, tbl_exp[i]);
      if (i > 0) begin
        chk($sformatf("logic%0d_wen", i - 1), o_write_en, 1);
        chk($sformatf("logic%0d_wdata", i - 1), o_write_data, tbl_exp[i - 1]);
      end
    end
    bubble();
    tick();
    chk("op13_wen", o_write_en, 0);

    // multiplies
    do_mul("mul300x7", 16'd300, 16'd7, 4'd4, 16'd2100);
    do_mul("mul256x256", 16'h0100, 16'h0100, 4'd6, 16'h0000);
    do_mul("mulffffx3", 16'hFFFF, 16'h0003, 4'd1, 16'hFFFD);

    // shifts
    drive(1'b1, OP_SHL, 4'd7, 1'b1, 16'h0001, 16'd15);
    tick();
    chk("shl_fwd_data", forward_dataE, 16'h8000);
    drive(1'b1, OP_SHR, 4'd8, 1'b1, 16'h8000, 16'd15);
    tick();
    bubble();
    chk("shr_fwd_data", forward_dataE, 16'h0001);
    chk("shl_wdata", o_write_data, 16'h8000);
    tick();
    chk("shr_wen", o_write_en, 1);
    chk("shr_wdata", o_write_data, 16'h0001);

    // flush during BUSY cycle 5 with an ADD waiting at the inputs
    drive(1'b1, OP_MUL, 4'd6, 1'b1, 16'd3, 16'd5);
    tick();
    drive(1'b1, OP_ADD, 4'd7, 1'b1, 16'd1, 16'd2);
    repeat (5) begin
      tick();
      chk("flush_pre_wen", o_write_en, 0);
    end
    chk("flush_busy5_stall", o_stall, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_stall_drop", o_stall, 0);
    chk("flush_fwd", forwardE, 0);
    chk("flush_wen", o_write_en, 0);
    tick();
    chk("flush_wen2", o_write_en, 0);
    chk("flush_next_fwd", forwardE, 1);
    chk("flush_next_add", forward_addE, 7);
    chk("flush_next_data", forward_dataE, 16'd3);
    bubble();
    tick();
    chk("flush_next_wen", o_write_en, 1);
    chk("flush_next_wdata", o_write_data, 16'd3);

    // ADD 0xFFFF + 1: wrap to zero with carry
    drive(1'b1, OP_ADD, 4'd2, 1'b1, 16'hFFFF, 16'h0001);
    tick();
    bubble();
    tick();
    chk("addwrap_wdata", o_write_data, 16'h0000);
    chk("addwrap_zero", o_zero, 1);
    chk("addwrap_carry", o_carry, 1);

    // reset in the middle of a multiply
    drive(1'b1, OP_MUL, 4'd4, 1'b1, 16'd300, 16'd7);
    tick();
    bubble();
    repeat (3) tick();
    chk("midmul_stall", o_stall, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midmul_reset");
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, OP_ADD, 4'd9, 1'b1, 16'h1234, 16'h0F0F);
    tick();
    bubble();
    chk("postrst_stall", o_stall, 0);
    chk("postrst_fwd_data", forward_dataE, 16'h2143);
    tick();
    chk("postrst_wen", o_write_en, 1);
    chk("postrst_wadd", o_write_add, 9);
    chk("postrst_wdata", o_write_data, 16'h2143);
    chk("postrst_carry", o_carry, 0);
    chk("postrst_zero", o_zero, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) pipeline stage of the 16-bit CPU, directly downstream of the register file. It latches decoded operands, computes the ALU result, and feeds that result back to the register file's execute-forwarding inputs. It then registers the result into the EX/WB latch that drives the register-file write port. Multiply is sequential (shift-add over 16 cycles), with a stall handshake to the front end.

## Interface
Parameters:
- DW, 16, data width
- AW, 4, register address width

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state
- i_valid  in  1  decoded instruction present
- i_op  in  4  opcode (cpu_pkg encoding)
- i_dest  in  AW  destination register
- i_wb  in  1  instruction writes a register
- i_data_a  in  DW  operand A (register-file o_read_data1)
- i_data_b  in  DW  operand B (o_read_data2; already zero-extended immediate when immediateC)
- i_flush  in  1  kill instruction in EX, abort multiply
- o_stall  out  1  front end must hold i_* and PC
- forwardE  out  1  EX result valid for forwarding
- forward_addE  out  AW  EX destination
- forward_dataE  out  DW  EX result
- o_write_en  out  1  write-back enable to register file
- o_write_add  out  AW  write-back address
- o_write_data  out  DW  write-back data
- o_zero, o_carry  out  1 each  status flags

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT (~A), 7 SHL (A<<B[3:0]), 8 SHR logical, 9 MOV (B), 10 MUL, 11 CMP (A−B, flags only, no write), 12–15 treated as NOP.
- ID/EX latch (ex_valid, ex_op, ex_dest, ex_wb, ex_a, ex_b): loads on posedge when o_stall=0. Loads ex_valid=0 when i_flush=1.
- ALU is combinational on the ID/EX latch. ADD/SUB use a 17-bit sum; the carry is bit 16. For SUB/CMP, carry=1 means borrow (A<B). Results are truncated to 16 bits.
- MUL FSM (sub-module mul16_seq):
  - IDLE → BUSY when ex_valid and ex_op==MUL. Loads acc=0, mcand=ex_a, mplier=ex_b, cnt=0.
  - BUSY, each cycle: if mplier[0], acc+=mcand (mod 2^16); then mcand<<=1, mplier>>=1, cnt++. Goes to DONE after cnt==15.
  - DONE → IDLE on the next posedge; result = acc (low 16 bits of the product).
- o_stall = ex_valid and ex_op==MUL and state≠DONE.
- forwardE = ex_valid and ex_wb and not o_stall and op≠CMP. forward_addE=ex_dest; forward_dataE=ALU/MUL result.
- EX/WB latch, on posedge when not o_stall:
  - o_write_en = ex_valid and ex_wb and op∉{NOP,CMP,12–15}
  - o_write_add = ex_dest; o_write_data = result
  - Flags update only for ADD/SUB/CMP: zero = (result16==0); carry as above.
  - When o_stall=1, o_write_en is 0.
- i_flush while BUSY: FSM → IDLE, ex_valid → 0, no write-back, stall drops next cycle.

## Timing
- Reset: every output and all state are 0; FSM in IDLE.
- Single-cycle op: latched at edge N, forwardE valid during cycle N. o_write_en is high during cycle N+1. The register file writes at the negedge of cycle N+1.
- MUL: latched at edge N; stall is high for 17 cycles (IDLE→BUSY edge plus 16 BUSY). forwardE is high in DONE, cycle N+17; write-back is in cycle N+18.
- A back-to-back dependent instruction sees the forwarded value in the same cycle its producer sits in EX.
- i_flush has priority over a new load. i_flush and i_valid in the same cycle: the instruction is discarded.
- Reset mid-multiply: immediate return to IDLE, outputs 0.

## Structure
- cpu_pkg: opcode localparams, DW/AW, FSM state encoding (IDLE=0, BUSY=1, DONE=2).
- One sub-module, mul16_seq: FSM, counter and shift-add datapath; outputs busy, done and product.
- The ALU stays inline in execute_stage.

## Test plan
- Reset, then ADD A=0x7FFF, B=0x0001, dest 3 → forwardE=1, forward_dataE=0x8000 same cycle; next cycle o_write_en=1, add=3; carry=0, zero=0.
- SUB A=5, B=5, then CMP A=3, B=4 → SUB: zero=1, carry=0, write 0x0000. CMP: carry=1, zero=0, o_write_en=0, forwardE=0.
- MUL A=300, B=7 → o_stall high exactly 17 cycles; forward_dataE=2100 in DONE; write next cycle. MUL 0x0100×0x0100 → 0x0000.
- SHL A=0x0001, B=15 → 0x8000; SHR A=0x8000, B=15 → 0x0001.
- i_flush during BUSY cycle 5 → no write-back, stall low next cycle, next instruction loads normally.
- Reset asserted mid-MUL → all outputs 0 asynchronously; after release, ADD executes correctly.
